// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin, burst-limited arbiter that shares one Avalon-MM
// SRAM port (mem_if) between M0 (stimulus reader) and M1 (result writer/host).
// Ports: clock, reset_n (async, active-low);
//   m0_*/m1_*  master ports (address, byteenable, read, write, writedata in;
//              readdata, readdataready, waitrequest out)
//   s_*        slave side towards mem_if
//   pend_count outstanding reads, rd_err sticky orphan-readdata flag
//   stat_m0/stat_m1/stat_cont statistics counters
// Optional feature: define MEM_ARB_STATS_EN to build saturating statistics
// counters; when undefined the stat_* outputs are tied to zero.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int PEND_DEPTH = 8,
    parameter int PEND_WIDTH = 3,
    parameter int BURST_MAX  = 8,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [BE_WIDTH-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_WIDTH-1:0] m0_writedata,
    output logic [DATA_WIDTH-1:0] m0_readdata,
    output logic                  m0_readdataready,
    output logic                  m0_waitrequest,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [BE_WIDTH-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_WIDTH-1:0] m1_writedata,
    output logic [DATA_WIDTH-1:0] m1_readdata,
    output logic                  m1_readdataready,
    output logic                  m1_waitrequest,
    output logic [ADDR_WIDTH-1:0] s_address,
    output logic [BE_WIDTH-1:0]   s_byteenable,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_WIDTH-1:0] s_writedata,
    input  logic [DATA_WIDTH-1:0] s_readdata,
    input  logic                  s_readdataready,
    input  logic                  s_waitrequest,
    output logic [PEND_WIDTH:0]   pend_count,
    output logic                  rd_err,
    output logic [STAT_WIDTH-1:0] stat_m0,
    output logic [STAT_WIDTH-1:0] stat_m1,
    output logic [STAT_WIDTH-1:0] stat_cont
);

    localparam int BW = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_gnt_q, last_gnt_d;

    logic [BW-1:0] burst_q, burst_d;
    logic [BW:0]   burst_inc;
    logic          burst_hit;
    logic [BW-1:0] burst_sat;

    logic req0, req1;
    logic gnt0, gnt1;

    logic [ADDR_WIDTH-1:0] g_addr;
    logic [BE_WIDTH-1:0]   g_be;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic                  g_read;
    logic                  g_write;
    logic                  g_wait;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  head_tag;

    logic [PEND_DEPTH-1:0] tag_mem;
    logic [PEND_WIDTH-1:0] wr_ptr;
    logic [PEND_WIDTH-1:0] rd_ptr;
    logic [PEND_WIDTH:0]   pend_q;
    logic                  rd_err_q;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;
    assign gnt0 = (state_q == GNT0);
    assign gnt1 = (state_q == GNT1);

    // Mux of the granted master; everything idles to zero in IDLE.
    always_comb begin
        g_addr  = '0;
        g_be    = '0;
        g_wdata = '0;
        g_read  = 1'b0;
        g_write = 1'b0;
        unique case (state_q)
            GNT0: begin
                g_addr  = m0_address;
                g_be    = m0_byteenable;
                g_wdata = m0_writedata;
                g_read  = m0_read;
                g_write = m0_write;
            end
            GNT1: begin
                g_addr  = m1_address;
                g_be    = m1_byteenable;
                g_wdata = m1_writedata;
                g_read  = m1_read;
                g_write = m1_write;
            end
            default: ;
        endcase
    end

    assign fifo_full  = (pend_q == (PEND_WIDTH+1)'(PEND_DEPTH));
    assign fifo_empty = (pend_q == '0);

    // Read wins over write; a read with no free tag slot is held off.
    assign s_read       = g_read & ~fifo_full;
    assign s_write      = g_write & ~g_read;
    assign s_address    = g_addr;
    assign s_byteenable = g_be;
    assign s_writedata  = g_wdata;

    assign g_wait         = s_waitrequest | (g_read & fifo_full);
    assign m0_waitrequest = gnt0 ? g_wait : 1'b1;
    assign m1_waitrequest = gnt1 ? g_wait : 1'b1;

    assign accept = (s_read | s_write) & ~s_waitrequest;
    assign push   = s_read & ~s_waitrequest;
    assign pop    = s_readdataready & ~fifo_empty;

    assign head_tag         = tag_mem[rd_ptr];
    assign m0_readdataready = pop & ~head_tag;
    assign m1_readdataready = pop & head_tag;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

    assign pend_count = pend_q;
    assign rd_err     = rd_err_q;

    // Burst count including this cycle's accept; held at BURST_MAX so a
    // lone master can keep streaming without the counter wrapping.
    assign burst_inc = {1'b0, burst_q} + {{BW{1'b0}}, accept};
    assign burst_hit = (burst_inc >= (BW+1)'(BURST_MAX));
    assign burst_sat = burst_hit ? BW'(BURST_MAX) : burst_inc[BW-1:0];

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        burst_d    = burst_q;
        unique case (state_q)
            IDLE: begin
                if (req0 & req1) begin
                    state_d = last_gnt_q ? GNT0 : GNT1;
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!req0 || (burst_hit && req1)) begin
                    last_gnt_d = 1'b0;
                    burst_d    = '0;
                    state_d    = req1 ? GNT1 : IDLE;
                end else begin
                    burst_d = burst_sat;
                end
            end
            GNT1: begin
                if (!req1 || (burst_hit && req0)) begin
                    last_gnt_d = 1'b1;
                    burst_d    = '0;
                    state_d    = req0 ? GNT0 : IDLE;
                end else begin
                    burst_d = burst_sat;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            burst_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            burst_q    <= burst_d;
        end
    end

    // Tag FIFO: one bit per outstanding read naming the issuing master.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_mem  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pend_q   <= '0;
            rd_err_q <= 1'b0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= gnt1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                pend_q <= pend_q + 1'b1;
            end else if (pop && !push) begin
                pend_q <= pend_q - 1'b1;
            end
            if (s_readdataready && fifo_empty) begin
                rd_err_q <= 1'b1;
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] cnt_m0_q;
    logic [STAT_WIDTH-1:0] cnt_m1_q;
    logic [STAT_WIDTH-1:0] cnt_cont_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_m0_q   <= '0;
            cnt_m1_q   <= '0;
            cnt_cont_q <= '0;
        end else begin
            if (accept && gnt0 && !(&cnt_m0_q)) begin
                cnt_m0_q <= cnt_m0_q + 1'b1;
            end
            if (accept && gnt1 && !(&cnt_m1_q)) begin
                cnt_m1_q <= cnt_m1_q + 1'b1;
            end
            if (req0 && req1 && !(&cnt_cont_q)) begin
                cnt_cont_q <= cnt_cont_q + 1'b1;
            end
        end
    end

    assign stat_m0   = cnt_m0_q;
    assign stat_m1   = cnt_m1_q;
    assign stat_cont = cnt_cont_q;
`else
    assign stat_m0   = '0;
    assign stat_m1   = '0;
    assign stat_cont = '0;
`endif

endmodule
